// File: rtl/ad_multi_pkg.sv
// Shared types and defaults for the multi-channel serial ADC scanner.
// AVG_N/AVG_SH are only consumed when AD_MULTI_AVG_EN is defined.
package ad_multi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int DEF_DATA_W   = 8;
   localparam int DEF_CH_N     = 4;
   localparam int DEF_CLK_DIV  = 2;
   localparam int DEF_CONV_CYC = 20;

   localparam int AVG_N  = 4;
   localparam int AVG_SH = 2;

endpackage

// File: rtl/ad_multi_if.sv
// Serial ADC pin bundle: master is the scanner, slave is the converter.
interface ad_multi_if;

   logic adcs;
   logic adclk;
   logic ad_din;
   logic ad_data;

   modport master (output adcs, output adclk, output ad_din, input ad_data);
   modport slave  (input adcs, input adclk, input ad_din, output ad_data);

endinterface

// File: rtl/ad_multi_clkgen.sv
// adclk divider: CLK_DIV clk cycles per half period while en is high, parked low otherwise.
// rise/fall flag the cycle whose closing clk edge toggles adclk 0->1 / 1->0.
module ad_clkgen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic adclk,
   output logic rise,
   output logic fall
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div;
   logic          tick;

   assign tick = en && (div == DW'(CLK_DIV - 1));
   assign rise = tick && !adclk;
   assign fall = tick && adclk;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div   <= '0;
         adclk <= 1'b0;
      end else if (!en) begin
         div   <= '0;
         adclk <= 1'b0;
      end else if (tick) begin
         div   <= '0;
         adclk <= ~adclk;
      end else begin
         div <= div + 1'b1;
      end
   end

endmodule

// File: rtl/ad_multi.sv
// Multi-channel serial ADC scanner: converts enabled channels in ascending order, single or continuous.
// Define AD_MULTI_AVG_EN to convert each channel AVG_N times and report the truncated mean.
module ad_multi
   import ad_multi_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int CH_N     = DEF_CH_N,
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int CONV_CYC = DEF_CONV_CYC,
   localparam int ADDR_W  = $clog2(CH_N)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              mode_cont,
   input  logic [CH_N-1:0]   ch_mask,
   ad_multi_if.master        ad,
   output logic [DATA_W-1:0] data,
   output logic [ADDR_W-1:0] data_ch,
   output logic              data_valid,
   output logic              isdone,
   output logic              busy,
   output state_t            dbg_state
);

   // Handshake: start is a one-cycle request taken only while busy is low and
   // ch_mask is non-zero; busy is the inverse of ready, data_valid/isdone are
   // single-cycle strobes with no back-pressure.

   localparam int CMAX = (CLK_DIV > CONV_CYC) ? CLK_DIV : CONV_CYC;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int BW   = $clog2(DATA_W + 1);

   state_t            state;
   logic [CH_N-1:0]   mask_l;
   logic              cont_l;
   logic [ADDR_W-1:0] cur;
   logic [ADDR_W-1:0] adr_sh;
   logic [DATA_W-1:0] sh;
   logic [CW-1:0]     cnt;
   logic [BW-1:0]     bit_cnt;
   logic              fin;
   logic              rise;
   logic              fall;
   logic              nxt_found;
   logic [ADDR_W-1:0] nxt_ch;
   logic [ADDR_W-1:0] tgt;
   logic              hold_go;
   logic              conv_final;
   logic              rep_ch;
   logic [DATA_W-1:0] result;

   assign dbg_state = state;

   function automatic logic [ADDR_W-1:0] lowest(input logic [CH_N-1:0] m);
      logic [ADDR_W-1:0] r;
      r = '0;
      for (int i = CH_N - 1; i >= 0; i--) begin
         if (m[i]) r = ADDR_W'(i);
      end
      return r;
   endfunction

   always_comb begin
      nxt_found = 1'b0;
      nxt_ch    = '0;
      for (int i = CH_N - 1; i >= 0; i--) begin
         if (mask_l[i] && (i > int'(cur))) begin
            nxt_found = 1'b1;
            nxt_ch    = ADDR_W'(i);
         end
      end
   end

   // Channel the next SETUP will address, whether entered from IDLE or HOLD.
   always_comb begin
      if (state == IDLE)   tgt = lowest(ch_mask);
      else if (rep_ch)     tgt = cur;
      else if (nxt_found)  tgt = nxt_ch;
      else                 tgt = lowest(mask_l);
   end

   assign hold_go = rep_ch || nxt_found || cont_l;

`ifdef AD_MULTI_AVG_EN
   logic [DATA_W+1:0] acc;
   logic [DATA_W+1:0] sum;
   logic [1:0]        avg_cnt;

   assign sum        = acc + {2'b00, sh};
   assign conv_final = (avg_cnt == 2'(AVG_N - 1));
   assign rep_ch     = (avg_cnt != 2'd0);
   assign result     = sum[DATA_W+1:AVG_SH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc     <= '0;
         avg_cnt <= 2'd0;
      end else if (state == SHIFT && fin) begin
         if (conv_final) begin
            acc     <= '0;
            avg_cnt <= 2'd0;
         end else begin
            acc     <= sum;
            avg_cnt <= avg_cnt + 2'd1;
         end
      end
   end
`else
   assign conv_final = 1'b1;
   assign rep_ch     = 1'b0;
   assign result     = sh;
`endif

   // fin holds the divider off for one cycle after the last fall, so the
   // result is published with adclk already parked low.
   ad_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk   (clk),
      .rstn  (rstn),
      .en    ((state == SHIFT) && !fin),
      .adclk (ad.adclk),
      .rise  (rise),
      .fall  (fall)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         ad.adcs    <= 1'b1;
         ad.ad_din  <= 1'b0;
         data       <= '0;
         data_ch    <= '0;
         data_valid <= 1'b0;
         isdone     <= 1'b0;
         busy       <= 1'b0;
         mask_l     <= '0;
         cont_l     <= 1'b0;
         cur        <= '0;
         adr_sh     <= '0;
         sh         <= '0;
         cnt        <= '0;
         bit_cnt    <= '0;
         fin        <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         isdone     <= 1'b0;
         case (state)
            IDLE: begin
               if (start && (|ch_mask)) begin
                  mask_l    <= ch_mask;
                  cont_l    <= mode_cont;
                  busy      <= 1'b1;
                  cur       <= tgt;
                  ad.ad_din <= tgt[ADDR_W-1];
                  adr_sh    <= tgt << 1;
                  ad.adcs   <= 1'b0;
                  cnt       <= '0;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               if (cnt == CW'(CLK_DIV - 1)) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  fin     <= 1'b0;
                  state   <= SHIFT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (fin) begin
                  fin       <= 1'b0;
                  ad.adcs   <= 1'b1;
                  ad.ad_din <= 1'b0;
                  cnt       <= '0;
                  state     <= HOLD;
                  if (conv_final) begin
                     data       <= result;
                     data_ch    <= cur;
                     data_valid <= 1'b1;
                     isdone     <= !nxt_found;
                     if (!nxt_found) cont_l <= mode_cont;
                  end
               end else begin
                  if (rise) sh <= {sh[DATA_W-2:0], ad.ad_data};
                  if (fall) begin
                     ad.ad_din <= adr_sh[ADDR_W-1];
                     adr_sh    <= adr_sh << 1;
                     if (bit_cnt == BW'(DATA_W - 1)) fin <= 1'b1;
                     else bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (cnt == CW'(CONV_CYC - 1)) begin
                  cnt <= '0;
                  if (hold_go) begin
                     cur       <= tgt;
                     ad.ad_din <= tgt[ADDR_W-1];
                     adr_sh    <= tgt << 1;
                     ad.adcs   <= 1'b0;
                     state     <= SETUP;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad_multi.sv
// Bench for ad_multi: ADC pin model, per-scenario tasks, expected-result queue.
// Honours AD_MULTI_AVG_EN (AVG_N conversions per channel, mean reported).
module tb_ad_multi;
   import ad_multi_pkg::*;

   localparam int DATA_W   = 8;
   localparam int CH_N     = 4;
   localparam int CLK_DIV  = 2;
   localparam int CONV_CYC = 20;
   localparam int ADDR_W   = $clog2(CH_N);
`ifdef AD_MULTI_AVG_EN
   localparam int NCONV = AVG_N;
`else
   localparam int NCONV = 1;
`endif
   localparam int CONV_LAT  = 1 + CLK_DIV + 2 * CLK_DIV * DATA_W;
   localparam int LAT_FIRST = CONV_LAT + (NCONV - 1) * (CONV_LAT + CONV_CYC);
   localparam int LAT_NEXT  = NCONV * (CONV_LAT + CONV_CYC);
   localparam int EW        = 1 + ADDR_W + DATA_W;
   localparam int TIMEOUT   = 3000;

   logic              clk;
   logic              rstn;
   logic              start;
   logic              mode_cont;
   logic [CH_N-1:0]   ch_mask;
   logic [DATA_W-1:0] data;
   logic [ADDR_W-1:0] data_ch;
   logic              data_valid;
   logic              isdone;
   logic              busy;
   state_t            dbg_state;

   ad_multi_if ad();

   ad_multi #(.DATA_W(DATA_W), .CH_N(CH_N), .CLK_DIV(CLK_DIV), .CONV_CYC(CONV_CYC)) dut (
      .clk(clk), .rstn(rstn), .start(start), .mode_cont(mode_cont), .ch_mask(ch_mask),
      .ad(ad), .data(data), .data_ch(data_ch), .data_valid(data_valid),
      .isdone(isdone), .busy(busy), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] adc_q[$];
   logic [ADDR_W-1:0] addr_q[$];
   logic [EW-1:0]     exp_q[$];

   // ADC model: word loaded on chip-select fall, next bit presented after each adclk rise.
   logic [DATA_W-1:0] adc_w;
   int                adc_bit;
   int                rise_n;
   logic [ADDR_W-1:0] addr_cap;
   int                cs_falls = 0;

   always @(negedge ad.adcs or posedge ad.adclk) begin
      if (ad.adclk) begin
         if (rise_n < ADDR_W) addr_cap[ADDR_W-1-rise_n] = ad.ad_din;
         rise_n++;
         if (adc_bit > 0) adc_bit--;
         ad.ad_data = adc_w[adc_bit];
      end else begin
         cs_falls++;
         adc_w    = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
         adc_bit  = DATA_W - 1;
         rise_n   = 0;
         addr_cap = '0;
         ad.ad_data = adc_w[adc_bit];
      end
   end

   always @(posedge ad.adcs) if (rstn) addr_q.push_back(addr_cap);

   task automatic add_ch(input int ch, input logic last, input logic [DATA_W-1:0] w);
      repeat (NCONV) adc_q.push_back(w);
      exp_q.push_back({last, ADDR_W'(ch), w});
   endtask

   task automatic add_ch_rand(input int ch, input logic last);
      int sum = 0;
      logic [DATA_W-1:0] w;
      for (int k = 0; k < NCONV; k++) begin
         w = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
         adc_q.push_back(w);
         sum += int'(w);
      end
      exp_q.push_back({last, ADDR_W'(ch), DATA_W'(sum / NCONV)});
   endtask

   task automatic model_scan(input logic [CH_N-1:0] m);
      int hi = 0;
      for (int i = 0; i < CH_N; i++) if (m[i]) hi = i;
      for (int i = 0; i < CH_N; i++) if (m[i]) add_ch_rand(i, i == hi);
   endtask

   task automatic pulse_start(input logic [CH_N-1:0] m, input logic c);
      @(negedge clk);
      ch_mask = m; mode_cont = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_dv(output int n, output bit ok);
      n = 0; ok = 1'b0;
      while (!ok && n < TIMEOUT) begin
         @(posedge clk); #1;
         n++;
         if (data_valid) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(output bit ok, output int dvs);
      int n = 0;
      dvs = 0;
      while (busy && n < TIMEOUT) begin
         @(posedge clk); #1;
         n++;
         if (data_valid) dvs++;
      end
      ok = !busy;
   endtask

   task automatic test_reset();
      rstn = 1'b0; start = 1'b0; mode_cont = 1'b0; ch_mask = '0;
      #23;
      checks++;
      if ({ad.adcs, ad.adclk, ad.ad_din, data, data_ch, data_valid, isdone, busy} !==
          {1'b1, 1'b0, 1'b0, {DATA_W{1'b0}}, {ADDR_W{1'b0}}, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_outputs got adcs=%b adclk=%b din=%b data=%h ch=%0d dv=%b done=%b busy=%b",
                  ad.adcs, ad.adclk, ad.ad_din, data, data_ch, data_valid, isdone, busy);
      end
      checks++;
      if (dbg_state !== IDLE) begin
         errors++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, IDLE);
      end
      @(negedge clk); rstn = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (cs_falls !== 0 || ad.adcs !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_release_quiet got cs_falls=%0d adcs=%b busy=%b want 0/1/0",
                            cs_falls, ad.adcs, busy);
      end
   endtask

   task automatic test_single();
      int n; bit ok; int dvs; logic [EW-1:0] e; logic [CH_N-1:0] m;
      add_ch(0, 1'b1, 8'hA5);
      pulse_start(4'b0001, 1'b0);
      wait_dv(n, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout waited=%0d", n); end
      checks++;
      if (n !== LAT_FIRST) begin errors++; $display("FAIL single_latency got=%0d want=%0d", n, LAT_FIRST); end
      e = exp_q.pop_front();
      checks++;
      if ({isdone, data_ch, data} !== e) begin
         errors++; $display("FAIL single_result got=%h want=%h", {isdone, data_ch, data}, e);
      end
      repeat (CONV_CYC - 1) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold got=%b want=1", busy); end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || dbg_state !== IDLE) begin
         errors++; $display("FAIL single_busy_fall got busy=%b state=%0d want 0/IDLE", busy, dbg_state);
      end
      for (int r = 0; r < 3; r++) begin
         m = '0;
         m[$urandom_range(0, CH_N - 1)] = 1'b1;
         model_scan(m);
         pulse_start(m, 1'b0);
         wait_dv(n, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || {isdone, data_ch, data} !== e) begin
            errors++; $display("FAIL single_rand_%0d got=%h want=%h ok=%b", r, {isdone, data_ch, data}, e, ok);
         end
         wait_idle(ok, dvs);
         checks++;
         if (!ok || dvs !== 0) begin
            errors++; $display("FAIL single_rand_idle_%0d extra_dv=%0d idle=%b want 0/1", r, dvs, ok);
         end
      end
   endtask

   task automatic test_scan();
      int n; bit ok; int dvs; int nexp; logic [EW-1:0] e; logic [CH_N-1:0] m; logic [ADDR_W-1:0] a;
      for (int r = 0; r < 4; r++) begin
         addr_q.delete();
         if (r == 0) begin
            m = 4'b1010;
            add_ch(1, 1'b0, 8'h3C);
            add_ch(3, 1'b1, 8'hC3);
         end else begin
            m = CH_N'($urandom_range(1, (1 << CH_N) - 1));
            model_scan(m);
         end
         nexp = $countones(m);
         pulse_start(m, 1'b0);
         for (int i = 0; i < nexp; i++) begin
            wait_dv(n, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || n !== ((i == 0) ? LAT_FIRST : LAT_NEXT)) begin
               errors++; $display("FAIL scan%0d_latency_%0d got=%0d want=%0d ok=%b", r, i, n,
                                  (i == 0) ? LAT_FIRST : LAT_NEXT, ok);
            end
            checks++;
            if ({isdone, data_ch, data} !== e) begin
               errors++; $display("FAIL scan%0d_result_%0d got=%h want=%h", r, i, {isdone, data_ch, data}, e);
            end
         end
         wait_idle(ok, dvs);
         checks++;
         if (!ok || dvs !== 0) begin
            errors++; $display("FAIL scan%0d_idle extra_dv=%0d idle=%b", r, dvs, ok);
         end
         if (r == 0) begin
            checks++;
            if (addr_q.size() !== 2 * NCONV) begin
               errors++; $display("FAIL scan_addr_count got=%0d want=%0d", addr_q.size(), 2 * NCONV);
            end else begin
               for (int k = 0; k < 2 * NCONV; k++) begin
                  a = addr_q.pop_front();
                  checks++;
                  if (a !== ((k < NCONV) ? 2'b01 : 2'b11)) begin
                     errors++; $display("FAIL scan_addr_%0d got=%b want=%b", k, a, (k < NCONV) ? 2'b01 : 2'b11);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_cont();
      int n; bit ok; int dvs; int cf; int want; logic [EW-1:0] e;
      localparam int DLY = 30;
      repeat (3) model_scan(4'b0011);
      pulse_start(4'b0011, 1'b1);
      for (int i = 0; i < 6; i++) begin
         wait_dv(n, ok);
         want = (i == 0) ? LAT_FIRST : ((i == 4) ? LAT_NEXT - DLY + 1 : LAT_NEXT);
         e = exp_q.pop_front();
         checks++;
         if (!ok || n !== want || {isdone, data_ch, data} !== e) begin
            errors++; $display("FAIL cont_conv_%0d got=%h lat=%0d want=%h lat=%0d ok=%b",
                               i, {isdone, data_ch, data}, n, e, want, ok);
         end
         if (i == 3) begin
            repeat (DLY) @(negedge clk);
            mode_cont = 1'b0;
         end
      end
      repeat (CONV_CYC - 1) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL cont_busy_hold got=%b want=1", busy); end
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy_fall got=%b want=0", busy); end
      cf = cs_falls;
      wait_idle(ok, dvs);
      repeat (100) @(posedge clk);
      #1;
      checks++;
      if (cs_falls !== cf) begin errors++; $display("FAIL cont_stopped cs_falls got=%0d want=%0d", cs_falls, cf); end
   endtask

   task automatic test_ignore();
      int n; bit ok; int dvs; int cf; logic [EW-1:0] e;
      cf = cs_falls;
      pulse_start(4'b0000, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (cs_falls !== cf || busy !== 1'b0) begin
         errors++; $display("FAIL ignore_zero_mask cs_falls=%0d want=%0d busy=%b", cs_falls, cf, busy);
      end
      add_ch(2, 1'b1, 8'h5A);
      pulse_start(4'b0100, 1'b0);
      repeat (10) @(negedge clk);
      pulse_start(4'b1111, 1'b0);
      wait_dv(n, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || {isdone, data_ch, data} !== e) begin
         errors++; $display("FAIL ignore_busy_result got=%h want=%h ok=%b", {isdone, data_ch, data}, e, ok);
      end
      wait_idle(ok, dvs);
      repeat (40) @(posedge clk);
      #1;
      checks++;
      if (cs_falls !== cf + NCONV || dvs !== 0) begin
         errors++; $display("FAIL ignore_busy_activity cs_falls=%0d want=%0d extra_dv=%0d", cs_falls, cf + NCONV, dvs);
      end
   endtask

   task automatic test_reset_mid();
      int n; bit ok; int dvs; int cf; logic [EW-1:0] e;
      add_ch_rand(2, 1'b1);
      pulse_start(4'b0100, 1'b0);
      repeat (15) @(posedge clk);
      #3;
      checks++;
      if (dbg_state !== SHIFT) begin errors++; $display("FAIL rstmid_pre_state got=%0d want=%0d", dbg_state, SHIFT); end
      rstn = 1'b0;
      #1;
      checks++;
      if ({ad.adcs, ad.adclk, data, busy, data_valid} !== {1'b1, 1'b0, {DATA_W{1'b0}}, 1'b0, 1'b0}) begin
         errors++; $display("FAIL rstmid_outputs got adcs=%b adclk=%b data=%h busy=%b dv=%b want 1/0/00/0/0",
                            ad.adcs, ad.adclk, data, busy, data_valid);
      end
      exp_q.delete(); adc_q.delete();
      @(negedge clk); rstn = 1'b1;
      addr_q.delete();
      cf = cs_falls;
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (cs_falls !== cf || ad.adcs !== 1'b1) begin
         errors++; $display("FAIL rstmid_quiet cs_falls=%0d want=%0d adcs=%b", cs_falls, cf, ad.adcs);
      end
      add_ch_rand(2, 1'b1);
      pulse_start(4'b0100, 1'b0);
      wait_dv(n, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || n !== LAT_FIRST || {isdone, data_ch, data} !== e) begin
         errors++; $display("FAIL rstmid_after got=%h lat=%0d want=%h lat=%0d", {isdone, data_ch, data}, n, e, LAT_FIRST);
      end
      wait_idle(ok, dvs);
   endtask

`ifdef AD_MULTI_AVG_EN
   task automatic test_avg();
      int n; bit ok; int dvs;
      adc_q.push_back(8'd10); adc_q.push_back(8'd11); adc_q.push_back(8'd12); adc_q.push_back(8'd13);
      pulse_start(4'b0001, 1'b0);
      wait_dv(n, ok);
      checks++;
      if (!ok || n !== LAT_FIRST || data !== 8'd11 || isdone !== 1'b1) begin
         errors++; $display("FAIL avg_result got=%0d lat=%0d done=%b want 11/%0d/1", data, n, isdone, LAT_FIRST);
      end
      wait_idle(ok, dvs);
      checks++;
      if (!ok || dvs !== 0) begin errors++; $display("FAIL avg_single_dv extra=%0d want=0", dvs); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_scan();
      test_cont();
      test_ignore();
      test_reset_mid();
`ifdef AD_MULTI_AVG_EN
      test_avg();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ad_multi.md
AD_MULTI -- requirements
Module: ad_multi

Interface
REQ-001 Parameter DATA_W, default 8: conversion result width, bits shifted per conversion.
REQ-002 Parameter CH_N, default 4: number of ADC input channels, 2..8; ADDR_W = clog2(CH_N).
REQ-003 Parameter CLK_DIV, default 2: adclk half-period in clk cycles, >=1.
REQ-004 Parameter CONV_CYC, default 20: clk cycles adcs is held high between conversions, >=1.
REQ-005 Port clk  in  1  single system clock; all logic rises on it.
REQ-006 Port rstn  in  1  asynchronous, active-low reset.
REQ-007 Port start  in  1  one-cycle request to begin a scan.
REQ-008 Port mode_cont  in  1  1 = rescan continuously, 0 = single scan.
REQ-009 Port ch_mask  in  CH_N  enabled channels, bit i = channel i.
REQ-010 Port ad_data  in  1  serial data from ADC, MSB first.
REQ-011 Port adcs  out  1  ADC chip select, active low.
REQ-012 Port adclk  out  1  ADC serial clock, idles low.
REQ-013 Port ad_din  out  ADDR_W... 1  serial channel address to ADC, MSB first.
REQ-014 Port data  out  DATA_W  last conversion result.
REQ-015 Port data_ch  out  ADDR_W  channel index of data.
REQ-016 Port data_valid  out  1  one-cycle strobe: data/data_ch updated.
REQ-017 Port isdone  out  1  one-cycle strobe: scan complete.
REQ-018 Port busy  out  1  high from start acceptance until return to IDLE.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD; all outputs registered.
REQ-020 IDLE: start=1 with ch_mask!=0 -> SETUP; ch_mask and mode_cont latched; start with ch_mask==0 ignored (no adcs activity).
REQ-021 start while busy SHALL be ignored.
REQ-022 Channels SHALL be converted in ascending index order, skipping zero mask bits.
REQ-023 SETUP: adcs low, adclk low, lasts CLK_DIV cycles, ad_din = address MSB.
REQ-024 SHIFT: DATA_W adclk periods, each CLK_DIV low then CLK_DIV high; ad_data sampled on the clk edge where adclk goes 0->1; ad_din changes on adclk 1->0, shifts address bits then 0.
REQ-025 End of SHIFT: adcs high, data/data_ch updated, data_valid=1 for one cycle, -> HOLD.
REQ-026 Latency: start accepted at edge k -> data_valid at edge k+1+CLK_DIV+2*CLK_DIV*DATA_W (35 for defaults).
REQ-027 HOLD: adcs high for CONV_CYC cycles, then SETUP for next enabled channel.
REQ-028 Last enabled channel: isdone pulses coincident with its data_valid; after HOLD -> IDLE (mode_cont=0) or first enabled channel (mode_cont=1).
REQ-029 mode_cont is resampled at each scan end; clearing it mid-scan completes the current scan, then IDLE.
REQ-030 Single-channel mask: each conversion asserts both data_valid and isdone.

Reset
REQ-031 rstn low SHALL immediately force: adcs=1, adclk=0, ad_din=0, data=0, data_ch=0, data_valid=0, isdone=0, busy=0, state IDLE; mid-conversion data discarded.
REQ-032 After rstn release no activity until next accepted start.

Configuration
REQ-033 Macro AD_MULTI_AVG_EN defined: each channel converted 4 times consecutively (HOLD between), data = (sum of 4) >> 2 truncated, single data_valid per channel after the 4th; undefined: one conversion per channel, no accumulator logic.

Structure
REQ-034 Package ad_multi_pkg SHALL hold FSM state enum, default parameter constants, AVG count (4).
REQ-035 Sub-module ad_clkgen SHALL generate adclk and rise/fall strobes from CLK_DIV.

Verification
REQ-036 Defaults, ch_mask=4'b0001, ad_data model returns 8'hA5 -> data=8'hA5, data_ch=0, data_valid and isdone 35 cycles after start.
REQ-037 ch_mask=4'b1010, model returns 8'h3C/8'hC3 -> data_valid for ch1 then ch3 with 3C,C3; isdone with ch3 only; ad_din shows 01 then 11.
REQ-038 mode_cont=1, ch_mask=4'b0011 -> repeated ch0,ch1 scans; clear mode_cont during ch0 -> ch1 completes, isdone, busy falls after HOLD.
REQ-039 start with ch_mask=0, and start pulsed mid-scan -> no extra adcs activity, scan unaffected.
REQ-040 rstn low mid-SHIFT -> adcs=1, adclk=0, data=0 in same cycle; next start yields correct full conversion.
REQ-041 AD_MULTI_AVG_EN defined, ch0 returns 10,11,12,13 -> single data_valid, data=11.
